// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 mux arbiter with a registered output stage
// Optional feature macro: ARB_PKT_LOCK_EN (packet lock: hold the grant until i_last)
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid, i_data, i_last per-requester valid, payload, end-of-packet
//   o_ready                 per-requester accept (one-hot or zero)
//   o_valid, o_data         registered output beat
//   o_grant_id              requester that produced o_data
//   i_ready                 downstream accept
module rr_mux_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_INPUTS-1:0]                i_valid,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] i_data,
    input  logic [NUM_INPUTS-1:0]                i_last,
    output logic [NUM_INPUTS-1:0]                o_ready,
    output logic                                 o_valid,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic [$clog2(NUM_INPUTS)-1:0]        o_grant_id,
    input  logic                                 i_ready
);
    localparam int IW = $clog2(NUM_INPUTS);

    generate
        if (NUM_INPUTS < 2 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0) begin : g_bad_cfg
            $fatal(1, "rr_mux_arbiter: NUM_INPUTS must be a power of two and >= 2");
        end
    endgenerate

    logic [IW-1:0]         r_last;
    logic [NUM_INPUTS-1:0] w_mask;
    logic [NUM_INPUTS-1:0] w_elig;
    logic [IW-1:0]         w_gnt;
    logic                  w_any;
    logic                  w_can_load;
    logic                  w_take;

    assign w_can_load = !o_valid || i_ready;
    assign w_elig     = i_valid & w_mask;

    // Scan downward so the closest requester after r_last is written last and wins;
    // index arithmetic wraps naturally because NUM_INPUTS is a power of two.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        for (int i = NUM_INPUTS; i >= 1; i--) begin
            if (w_elig[r_last + IW'(i)]) begin
                w_gnt = r_last + IW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign o_ready = (i_rst_n && w_can_load && w_any) ? (NUM_INPUTS'(1) << w_gnt) : '0;
    assign w_take  = |o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_grant_id <= '0;
            r_last     <= IW'(NUM_INPUTS - 1);
        end else if (w_take) begin
            o_valid    <= 1'b1;
            o_data     <= i_data[w_gnt];
            o_grant_id <= w_gnt;
            r_last     <= w_gnt;
        end else if (i_ready) begin
            o_valid    <= 1'b0;
        end
    end

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t r_state, w_state_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= UNLOCKED;
        else          r_state <= w_state_nxt;
    end

    // Any accepted beat either opens/continues a packet (i_last=0) or closes it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_take) w_state_nxt = i_last[w_gnt] ? UNLOCKED : LOCKED;
    end

    // While locked, r_last is the locked requester since only it can be granted.
    always_comb begin
        w_mask = (r_state == LOCKED) ? (NUM_INPUTS'(1) << r_last) : '1;
    end
`else
    assign w_mask = '1;
    logic w_unused;
    assign w_unused = ^i_last;
`endif

endmodule
